bus_mem_responder: RTL and testbench

//  Memory-side responder for the _6502 core bus (ab/do/di/we). Holds a byte RAM,

---
 rtl/bus_mem_responder.sv | 124 ++++++++++++
 tb/tb_bus_mem_responder.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// Byte RAM responder for the 6502 bus (ab/cpu_do/we/cpu_di) with a boot loader.
// Define ROM_PROTECT_EN to drop RUN-time CPU writes at ROM_BASE..DEPTH-1.
module bus_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [15:0] LOAD_BASE = 16'h0000,
  parameter int unsigned RST_HOLD  = 4,
  parameter logic [15:0] ROM_BASE  = 16'h0300
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] ab,
  input  logic [7:0]  cpu_do,
  input  logic        we,
  output logic [7:0]  cpu_di,
  output logic        cpu_reset,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        loaded,
  output logic        overflow,
  output logic        bus_err,
  output logic        wp_hit
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {
    LOAD,
    RELEASE,
    RUN
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          ovf_nx;
  logic          run, mapped, beat, prot, cpu_wr;
  logic [AW-1:0] idx;
  logic [7:0]    mem [DEPTH];

  assign run       = (state == RUN);
  assign mapped    = {1'b0, ab} < 17'(DEPTH);
  assign idx       = ab[AW-1:0];
  assign beat      = ld_valid & ld_ready;
  assign cpu_reset = ~run;
  assign loaded    = run;

`ifdef ROM_PROTECT_EN
  assign prot = run & we & mapped & (ab >= ROM_BASE);
`else
  logic unused_rom;
  assign unused_rom = ^ROM_BASE;
  assign prot       = 1'b0;
`endif

  assign cpu_wr = run & we & mapped & ~prot;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    ovf_nx   = overflow;
    unique case (state)
      LOAD: begin
        if (beat) begin
          // ptr saturates at the top so it can never wrap to 0
          if (ptr != AW'(DEPTH - 1))
            ptr_nx = ptr + 1'b1;
          if (ld_last)
            state_nx = RELEASE;
          else if (ptr == AW'(DEPTH - 1)) begin
            ovf_nx   = 1'b1;
            state_nx = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (cnt == CW'(RST_HOLD - 1))
          state_nx = RUN;
        else
          cnt_nx = cnt + 1'b1;
      end
      RUN: state_nx = RUN;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= LOAD;
      ptr      <= LOAD_BASE[AW-1:0];
      cnt      <= '0;
      ld_ready <= 1'b0;
      overflow <= 1'b0;
      bus_err  <= 1'b0;
      wp_hit   <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      cnt      <= cnt_nx;
      ld_ready <= (state_nx == LOAD);
      overflow <= ovf_nx;
      bus_err  <= run & ~mapped;
      wp_hit   <= prot;
    end
  end

  // RAM survives reset so a reloaded image can overlay older contents
  always_ff @(posedge clk) begin
    if (beat)
      mem[ptr] <= ld_data;
    else if (cpu_wr)
      mem[idx] <= cpu_do;
  end

  always_comb begin
    cpu_di = 8'hFF;
    if (!we && mapped)
      cpu_di = mem[idx];
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Randomized self-checking bench for bus_mem_responder.
// Main instance DEPTH=1024, small instance DEPTH=16 for overflow cases.
module tb_bus_mem_responder;

  localparam int DEPTH  = 1024;
  localparam int SDEPTH = 16;
  localparam int HOLD   = 4;
`ifdef ROM_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, s_reset_n;
  logic [15:0] ab, s_ab;
  logic [7:0]  cpu_do, s_cpu_do, cpu_di, s_cpu_di;
  logic        we, s_we, cpu_reset, s_cpu_reset;
  logic        ld_valid, s_ld_valid, ld_last, s_ld_last;
  logic [7:0]  ld_data, s_ld_data;
  logic        ld_ready, s_ld_ready, loaded, s_loaded;
  logic        overflow, s_overflow, bus_err, s_bus_err;
  logic        wp_hit, s_wp_hit;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_mem [DEPTH];
  logic [7:0] img [DEPTH];

  always #5 clk = ~clk;

  bus_mem_responder #(
    .DEPTH(DEPTH), .LOAD_BASE(16'h0000),
    .RST_HOLD(HOLD), .ROM_BASE(16'h0300)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ab(ab), .cpu_do(cpu_do),
    .we(we), .cpu_di(cpu_di), .cpu_reset(cpu_reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .loaded(loaded), .overflow(overflow),
    .bus_err(bus_err), .wp_hit(wp_hit)
  );

  bus_mem_responder #(
    .DEPTH(SDEPTH), .LOAD_BASE(16'h0000),
    .RST_HOLD(1), .ROM_BASE(16'h0300)
  ) sdut (
    .clk(clk), .reset_n(s_reset_n), .ab(s_ab), .cpu_do(s_cpu_do),
    .we(s_we), .cpu_di(s_cpu_di), .cpu_reset(s_cpu_reset),
    .ld_valid(s_ld_valid), .ld_data(s_ld_data), .ld_last(s_ld_last),
    .ld_ready(s_ld_ready), .loaded(s_loaded), .overflow(s_overflow),
    .bus_err(s_bus_err), .wp_hit(s_wp_hit)
  );

  task automatic test_reset;
    reset_n = 0; s_reset_n = 0;
    ab = 0; cpu_do = 0; we = 0; ld_valid = 0; ld_data = 0; ld_last = 0;
    s_ab = 0; s_cpu_do = 0; s_we = 0;
    s_ld_valid = 0; s_ld_data = 0; s_ld_last = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cpu_reset, ld_ready, loaded, overflow, bus_err, wp_hit} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outs: got %b expected 100000",
               {cpu_reset, ld_ready, loaded, overflow, bus_err, wp_hit});
    end
    checks++;
    if ({s_cpu_reset, s_ld_ready, s_overflow} !== 3'b100) begin
      errors++;
      $display("FAIL s_reset_outs: got %b expected 100",
               {s_cpu_reset, s_ld_ready, s_overflow});
    end
    reset_n = 1; s_reset_n = 1;
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b0) begin
      errors++; $display("FAIL ready_pre_edge: got %b expected 0", ld_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b1 || s_ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_rise: got %b/%b expected 1/1", ld_ready, s_ld_ready);
    end
    @(posedge clk); #1;
  endtask

  // feeds img[0..n-1] with random valid gaps and random CPU traffic
  task automatic load_main(input int n);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 20 * n + 100) begin
      ld_valid = ($urandom_range(3) != 0);
      ld_data  = img[idx];
      ld_last  = (idx == n - 1);
      we       = $urandom_range(1);
      ab       = 16'($urandom_range(DEPTH - 1));
      cpu_do   = 8'($urandom);
      @(negedge clk);
      checks++;
      if ({ld_ready, cpu_reset, loaded} !== 3'b110) begin
        errors++;
        $display("FAIL load_state idx %0d: got %b expected 110",
                 idx, {ld_ready, cpu_reset, loaded});
      end
      @(posedge clk); #1;
      if (ld_valid) begin
        model_mem[idx] = img[idx];
        idx++;
      end
      guard++;
    end
    if (idx < n) begin
      errors++;
      $display("FAIL load_timeout: got %0d beats expected %0d", idx, n);
    end
    ld_valid = 0; ld_last = 0;
    for (int c = 0; c < HOLD; c++) begin
      we = $urandom_range(1);
      ab = 16'($urandom_range(DEPTH - 1));
      cpu_do = 8'($urandom);
      ld_valid = $urandom_range(1);
      @(negedge clk);
      checks++;
      if ({ld_ready, cpu_reset, loaded} !== 3'b010) begin
        errors++;
        $display("FAIL hold_%0d: got %b expected 010",
                 c, {ld_ready, cpu_reset, loaded});
      end
      @(posedge clk); #1;
    end
    ld_valid = 0; we = 0; ab = 0;
    @(negedge clk);
    checks++;
    if ({ld_ready, cpu_reset, loaded} !== 3'b001) begin
      errors++;
      $display("FAIL run_entry: got %b expected 001",
               {ld_ready, cpu_reset, loaded});
    end
    @(posedge clk); #1;
  endtask

  task automatic readback_all(input string tag);
    logic [7:0] exp;
    for (int a = 0; a < DEPTH; a++) begin
      ab = 16'(a); we = 0;
      exp = model_mem[a];
      @(negedge clk);
      checks++;
      if (cpu_di !== exp) begin
        errors++;
        $display("FAIL %s @%h: got %h expected %h", tag, ab, cpu_di, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_load;
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
    img[0] = 8'hA9; img[1] = 8'h14; img[2] = 8'h8D; img[3] = 8'h14;
    load_main(DEPTH);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL last_at_top_overflow: got %b expected 0", overflow);
    end
    readback_all("full_load");
  endtask

  task automatic test_write_read;
    ab = 16'h0014; we = 1; cpu_do = 8'h55;
    @(negedge clk);
    checks++;
    if (cpu_di !== 8'hFF) begin
      errors++; $display("FAIL di_during_we: got %h expected ff", cpu_di);
    end
    @(posedge clk); #1;
    model_mem[16'h14] = 8'h55;
    we = 0;
    @(negedge clk);
    checks++;
    if (cpu_di !== 8'h55) begin
      errors++; $display("FAIL write_then_read: got %h expected 55", cpu_di);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unmapped;
    logic [7:0] keep;
    ab = 16'h8000; we = 0;
    @(negedge clk);
    checks++;
    if (cpu_di !== 8'hFF || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL unmapped_rd: got di %h err %b expected ff 0", cpu_di, bus_err);
    end
    @(posedge clk); #1;
    ab = 16'h0000;
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b1) begin
      errors++; $display("FAIL bus_err_pulse: got %b expected 1", bus_err);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0) begin
      errors++; $display("FAIL bus_err_clear: got %b expected 0", bus_err);
    end
    @(posedge clk); #1;
    keep = model_mem[0];
    ab = 16'h8000; we = 1; cpu_do = ~keep;
    @(posedge clk); #1;
    ab = 16'h0000; we = 0;
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b1 || cpu_di !== keep) begin
      errors++;
      $display("FAIL unmapped_wr: got err %b di %h expected 1 %h", bus_err, cpu_di, keep);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_protect;
    logic [7:0] v, exp;
    v = ~model_mem[16'h300];
    exp = PROT ? model_mem[16'h300] : v;
    ab = 16'h0300; we = 1; cpu_do = v;
    @(posedge clk); #1;
    we = 0;
    if (!PROT) model_mem[16'h300] = v;
    @(negedge clk);
    checks++;
    if (wp_hit !== PROT || cpu_di !== exp) begin
      errors++;
      $display("FAIL wp_0300: got wp %b di %h expected %b %h", wp_hit, cpu_di, PROT, exp);
    end
    @(posedge clk); #1;
    v = ~model_mem[16'h2FF];
    ab = 16'h02FF; we = 1; cpu_do = v;
    @(negedge clk);
    checks++;
    if (wp_hit !== 1'b0) begin
      errors++; $display("FAIL wp_pulse_len: got %b expected 0", wp_hit);
    end
    @(posedge clk); #1;
    we = 0;
    model_mem[16'h2FF] = v;
    @(negedge clk);
    checks++;
    if (wp_hit !== 1'b0 || cpu_di !== v) begin
      errors++;
      $display("FAIL wr_02ff: got wp %b di %h expected 0 %h", wp_hit, cpu_di, v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_run(input int n);
    logic prev_unm = 0, prev_wp = 0, unm, pr;
    logic [7:0] exp;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(3))
        0: ab = 16'($urandom_range(DEPTH - 1));
        1: ab = 16'h02F8 + 16'($urandom_range(15));
        2: ab = 16'($urandom_range(65535, DEPTH));
        default: ab = 16'($urandom_range(31));
      endcase
      we = $urandom_range(1);
      cpu_do = 8'($urandom);
      ld_valid = $urandom_range(1);
      ld_data = 8'($urandom);
      unm = (int'(ab) >= DEPTH);
      exp = (we || unm) ? 8'hFF : model_mem[ab[9:0]];
      @(negedge clk);
      checks++;
      if (cpu_di !== exp || bus_err !== prev_unm || wp_hit !== prev_wp) begin
        errors++;
        $display("FAIL rand_%0d @%h: got %h/%b/%b expected %h/%b/%b",
                 i, ab, cpu_di, bus_err, wp_hit, exp, prev_unm, prev_wp);
      end
      @(posedge clk); #1;
      pr = PROT && we && !unm && ab >= 16'h0300;
      if (we && !unm && !pr) model_mem[ab[9:0]] = cpu_do;
      prev_unm = unm;
      prev_wp = pr;
    end
    we = 0; ab = 0; ld_valid = 0;
    @(posedge clk); #1;
    readback_all("rand_after");
  endtask

  task automatic test_reset_mid_run;
    ab = 0; we = 0;
    @(negedge clk);
    reset_n = 0;
    #1;
    checks++;
    if ({cpu_reset, loaded, ld_ready} !== 3'b100 || cpu_di !== model_mem[0]) begin
      errors++;
      $display("FAIL reset_mid_run: got %b di %h expected 100 %h",
               {cpu_reset, loaded, ld_ready}, cpu_di, model_mem[0]);
    end
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) img[i] = 8'($urandom);
    load_main(8);
    readback_all("reload");
  endtask

  task automatic test_valid_gaps;
    bit pat [6] = '{1, 0, 1, 1, 0, 1};
    int k = 0;
    for (int i = 0; i < 6; i++) begin
      s_ld_valid = pat[i];
      s_ld_data  = pat[i] ? 8'(k + 1) : 8'hEE;
      s_ld_last  = pat[i] && (k == 3);
      @(negedge clk);
      checks++;
      if (s_ld_ready !== 1'b1) begin
        errors++; $display("FAIL gaps_ready_%0d: got %b expected 1", i, s_ld_ready);
      end
      @(posedge clk); #1;
      if (pat[i]) k++;
    end
    s_ld_valid = 0; s_ld_last = 0;
    @(negedge clk);
    checks++;
    if ({s_ld_ready, s_cpu_reset} !== 2'b01) begin
      errors++;
      $display("FAIL gaps_release: got %b expected 01", {s_ld_ready, s_cpu_reset});
    end
    @(posedge clk); #1;
    for (int a = 0; a < 4; a++) begin
      s_ab = 16'(a); s_we = 0;
      @(negedge clk);
      checks++;
      if (s_cpu_di !== 8'(a + 1) || s_cpu_reset !== 1'b0) begin
        errors++;
        $display("FAIL gaps_rd @%0d: got %h rst %b expected %h 0",
                 a, s_cpu_di, s_cpu_reset, 8'(a + 1));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow;
    s_reset_n = 0;
    #2;
    s_reset_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < SDEPTH + 1; i++) begin
      s_ld_valid = 1; s_ld_data = 8'(8'h10 + i); s_ld_last = 0;
      @(negedge clk);
      checks++;
      if (s_ld_ready !== (i < SDEPTH) || s_overflow !== (i >= SDEPTH)) begin
        errors++;
        $display("FAIL ovf_beat_%0d: got rdy %b ovf %b expected %b %b",
                 i, s_ld_ready, s_overflow, i < SDEPTH, i >= SDEPTH);
      end
      @(posedge clk); #1;
    end
    s_ld_valid = 0;
    for (int a = 0; a <= SDEPTH; a++) begin
      s_ab = 16'(a); s_we = 0;
      @(negedge clk);
      checks++;
      if (s_cpu_di !== ((a < SDEPTH) ? 8'(8'h10 + a) : 8'hFF) ||
          s_overflow !== 1'b1 || s_loaded !== 1'b1 || s_wp_hit !== 1'b0) begin
        errors++;
        $display("FAIL ovf_rd @%0d: got %h ovf %b ld %b", a, s_cpu_di, s_overflow, s_loaded);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (s_bus_err !== 1'b1) begin
      errors++; $display("FAIL s_bus_err_top: got %b expected 1", s_bus_err);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_valid_gaps();
    test_overflow();
    test_full_load();
    test_write_read();
    test_unmapped();
    test_protect();
    test_random_run(300);
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
